// File: rtl/pcm_pkg.sv
// pcm_pkg: shared FSM state type, datapath constants and the log volume table for pcm_stream
package pcm_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SCALE, OUT} state_t;
  localparam int SAMPLE_W = 16;
  localparam int VOL_SHIFT = 6;
  localparam logic [6:0] VOL_TAB [16] = '{7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd8,
                                          7'd11, 7'd14, 7'd18, 7'd23, 7'd30, 7'd38, 7'd49, 7'd64};
  function automatic logic [6:0] vol_log(input logic [3:0] v);
    return VOL_TAB[v];
  endfunction
endpackage

// File: rtl/pcm_fifo.sv
// pcm_fifo: show-ahead byte FIFO with level/full/empty, async rst, sync flush
//   write/wrdata push (dropped when full or flushing), pop advances rddata (ignored when empty),
//   level counts stored bytes.
module pcm_fifo #(
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     write,
  input  logic [7:0]               wrdata,
  input  logic                     pop,
  output logic [7:0]               rddata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic we, re;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign we = write && !full && !flush;
  assign re = pop && !empty && !flush;
  assign rddata = mem[rp];
  always_ff @(posedge clk)
    if (we) mem[wp] <= wrdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(we);
      rp <= rp + AW'(re);
      level <= level + (AW+1)'(we) - (AW+1)'(re);
    end
endmodule

// File: rtl/pcm_stream.sv
// pcm_stream: PCM playback engine, byte FIFO in, NCH scaled signed 16-bit lanes out
//   Inputs: next_sample tick, rate increment, active_ch/mode_16bit/volume frame config,
//   fifo_reset flush, fifo_write/fifo_wrdata byte writes.
//   Outputs: FIFO status, sticky underrun, audio_out lanes (ch0 in LSBs), audio_valid pulse.
//   Build option PCM_HOLD_ON_UNDERRUN_EN: underrun frames keep audio_out and issue no audio_valid.
module pcm_stream
  import pcm_pkg::*;
#(
  parameter int NCH = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int RATE_W = 8,
  parameter int AE_LEVEL = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          next_sample,
  input  logic [RATE_W-1:0]             rate,
  input  logic [2:0]                    active_ch,
  input  logic                          mode_16bit,
  input  logic [4*NCH-1:0]              volume,
  input  logic                          fifo_reset,
  input  logic [7:0]                    fifo_wrdata,
  input  logic                          fifo_write,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic                          fifo_almost_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic [SAMPLE_W*NCH-1:0]       audio_out,
  output logic                          audio_valid
);
`ifdef PCM_HOLD_ON_UNDERRUN_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif
  localparam logic [RATE_W-1:0] HALF = {1'b1, {(RATE_W-1){1'b0}}};
  state_t state, state_nx;
  logic [RATE_W-1:0] acc, acc_nx, rate_eff;
  logic new_frame, pop, start, under;
  logic [7:0] rddata;
  logic [2:0] a_in, a_r, ch, src;
  logic [3:0] a1, s_in, s_r, cnt, vsel;
  logic [4:0] b_in, b_r;
  logic m16_r;
  logic [4*NCH-1:0] vol_r;
  logic [7:0] stage [16];
  logic [SAMPLE_W-1:0] res [8];
  logic [SAMPLE_W-1:0] sample, scaled;
  logic signed [23:0] prod;

  pcm_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .flush(fifo_reset), .write(fifo_write), .wrdata(fifo_wrdata),
    .pop(pop), .rddata(rddata), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );

  assign fifo_almost_empty = int'(fifo_level) < AE_LEVEL;
  assign rate_eff = rate > HALF ? HALF : rate;
  assign acc_nx = acc + rate_eff;
  assign a_in = int'(active_ch) >= NCH ? 3'(NCH-1) : active_ch;
  assign a1 = {1'b0, a_in} + 4'd1;
  assign b_in = mode_16bit ? {a1, 1'b0} : {1'b0, a1};
  // a mono frame still scales every lane with its own volume, so it takes NCH scale steps
  assign s_in = a_in == 3'd0 ? 4'(NCH) : a1;
  assign start = state == IDLE && new_frame && !fifo_reset;
  assign under = int'(fifo_level) < int'(b_in);

  assign ch = cnt[2:0];
  assign src = a_r == 3'd0 ? 3'd0 : ch;
  assign sample = m16_r ? {stage[{src, 1'b1}], stage[{src, 1'b0}]} : {stage[{1'b0, src}], 8'h00};
  assign vsel = 4'(vol_r >> {ch, 2'b00});
  assign prod = $signed(sample) * $signed({1'b0, vol_log(vsel)});
  assign scaled = SAMPLE_W'(prod >>> VOL_SHIFT);

  always_comb begin
    state_nx = state;
    pop = 1'b0;
    if (fifo_reset) state_nx = IDLE;
    else
      case (state)
        IDLE:  if (new_frame) state_nx = under ? (HOLD ? IDLE : SCALE) : FETCH;
        FETCH: begin
          pop = 1'b1;
          state_nx = {1'b0, cnt} == b_r - 5'd1 ? SCALE : FETCH;
        end
        SCALE: state_nx = cnt == s_r - 4'd1 ? OUT : SCALE;
        default: state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      acc <= '0;
      new_frame <= 1'b0;
      underrun <= 1'b0;
      audio_valid <= 1'b0;
      audio_out <= '0;
      cnt <= '0;
      a_r <= '0;
      m16_r <= 1'b0;
      vol_r <= '0;
      b_r <= '0;
      s_r <= '0;
      for (int i = 0; i < 16; i++) stage[i] <= '0;
      for (int i = 0; i < 8; i++) res[i] <= '0;
    end else begin
      acc <= next_sample ? acc_nx : acc;
      new_frame <= next_sample && (acc_nx[RATE_W-1] != acc[RATE_W-1]);
      audio_valid <= state == OUT && !fifo_reset;
      // step counter restarts on every state change
      cnt <= state_nx != state ? 4'd0 : cnt + 4'd1;
      if (fifo_reset) underrun <= 1'b0;
      else if (start && under) underrun <= 1'b1;
      if (start) begin
        a_r <= a_in;
        m16_r <= mode_16bit;
        vol_r <= volume;
        b_r <= b_in;
        s_r <= s_in;
      end
      if (start && under) for (int i = 0; i < 16; i++) stage[i] <= '0;
      if (state == FETCH) stage[cnt] <= rddata;
      if (state == SCALE) res[ch] <= scaled;
      if (state == OUT && !fifo_reset)
        for (int l = 0; l < NCH; l++) audio_out[SAMPLE_W*l +: SAMPLE_W] <= 4'(l) < s_r ? res[l] : '0;
    end
endmodule

// File: tb/tb_pcm_stream.sv
// tb_pcm_stream: directed and randomized checks of pcm_stream against a frame-level model
module tb_pcm_stream;
  localparam int NCH = 2, DEPTH = 4096, RW = 8, AE = 1024, LW = $clog2(DEPTH) + 1;
  localparam int VT [16] = '{0, 1, 2, 3, 4, 5, 6, 8, 11, 14, 18, 23, 30, 38, 49, 64};
  logic clk = 0, rst = 1, next_sample = 0, mode_16bit = 0, fifo_reset = 0, fifo_write = 0;
  logic [RW-1:0] rate = '0;
  logic [2:0] active_ch = '0;
  logic [4*NCH-1:0] volume = '0;
  logic [7:0] fifo_wrdata = '0;
  logic fifo_full, fifo_empty, fifo_almost_empty, underrun, audio_valid;
  logic [LW-1:0] fifo_level;
  logic [16*NCH-1:0] audio_out;
  int tests = 0, fails = 0;
  logic [7:0] q [$];
  logic [15:0] exp_out [NCH];
  logic exp_ur = 0;

  pcm_stream #(.NCH(NCH), .FIFO_DEPTH(DEPTH), .RATE_W(RW), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst(rst), .next_sample(next_sample), .rate(rate), .active_ch(active_ch),
    .mode_16bit(mode_16bit), .volume(volume), .fifo_reset(fifo_reset), .fifo_wrdata(fifo_wrdata),
    .fifo_write(fifo_write), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_almost_empty(fifo_almost_empty), .fifo_level(fifo_level), .underrun(underrun),
    .audio_out(audio_out), .audio_valid(audio_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] scale(input logic [15:0] s, input logic [3:0] v);
    int p;
    p = int'($signed(s)) * VT[v];
    p = p >>> 6;
    return 16'(p);
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_wrdata = b;
    fifo_write = 1;
    tick();
    fifo_write = 0;
    if (q.size() < DEPTH) q.push_back(b);
  endtask

  task automatic flush();
    fifo_reset = 1;
    tick();
    fifo_reset = 0;
    q.delete();
    exp_ur = 0;
  endtask

  // consumes one frame from the byte queue; lat is the new_frame-to-valid delay, -1 when no pulse
  task automatic model(output int lat);
    int na, nb, ns;
    logic ur, hold;
    logic [15:0] smp [NCH];
    na = (int'(active_ch) >= NCH ? NCH - 1 : int'(active_ch)) + 1;
    nb = mode_16bit ? 2 * na : na;
    ns = na == 1 ? NCH : na;
    ur = q.size() < nb;
    hold = 0;
`ifdef PCM_HOLD_ON_UNDERRUN_EN
    hold = ur;
`endif
    for (int c = 0; c < NCH; c++) smp[c] = '0;
    if (!ur) begin
      for (int c = 0; c < na; c++) smp[c] = mode_16bit ? {q[2*c+1], q[2*c]} : {q[c], 8'h00};
      repeat (nb) void'(q.pop_front());
    end
    if (ur) exp_ur = 1;
    if (!hold)
      for (int l = 0; l < NCH; l++)
        exp_out[l] = (na > 1 && l >= na) ? 16'h0 : scale(smp[na == 1 ? 0 : l], volume[4*l +: 4]);
    lat = hold ? -1 : (ur ? ns + 2 : nb + ns + 2);
  endtask

  task automatic check_out(input string tag);
    for (int l = 0; l < NCH; l++)
      chk($sformatf("%s_lane%0d", tag, l), 32'(audio_out[16*l +: 16]), 32'(exp_out[l]));
  endtask

  task automatic do_frame(input string tag);
    int lat, k;
    logic got;
    model(lat);
    next_sample = 1;
    tick();
    next_sample = 0;
    k = 0;
    got = 0;
    while (!got && k < 40) begin
      tick();
      k++;
      got = audio_valid;
    end
    if (lat < 0) chk({tag, "_novalid"}, 32'(got), 0);
    else begin
      chk({tag, "_latency"}, k, lat);
      tick();
      chk({tag, "_pulse"}, 32'(audio_valid), 0);
    end
    check_out(tag);
    chk({tag, "_level"}, 32'(fifo_level), q.size());
    chk({tag, "_underrun"}, 32'(underrun), 32'(exp_ur));
  endtask

  initial begin
    int nv, lat;
    for (int l = 0; l < NCH; l++) exp_out[l] = '0;
    repeat (3) tick();
    chk("rst_out", audio_out, 0);
    chk("rst_valid", 32'(audio_valid), 0);
    chk("rst_empty", 32'(fifo_empty), 1);
    chk("rst_ae", 32'(fifo_almost_empty), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_full", 32'(fifo_full), 0);
    rst = 0;
    tick();

    rate = 8'd128; active_ch = 3'd0; mode_16bit = 0; volume = 8'hFF;
    push(8'h40);
    do_frame("t1");
    chk("t1_const0", 32'(audio_out[15:0]), 32'h4000);
    chk("t1_const1", 32'(audio_out[31:16]), 32'h4000);

    active_ch = 3'd1; mode_16bit = 1; volume = 8'hF8;
    push(8'h34); push(8'h12); push(8'hCD); push(8'hAB);
    do_frame("t2");
    chk("t2_const0", 32'(audio_out[15:0]), 32'h0320);
    chk("t2_const1", 32'(audio_out[31:16]), 32'hABCD);

    repeat (3) push(8'($urandom));
    do_frame("t3");
    flush();
    chk("flush_level", 32'(fifo_level), 0);
    chk("flush_underrun", 32'(underrun), 0);

    rate = 8'd0;
    push(8'h11);
    next_sample = 1; tick(); next_sample = 0;
    nv = 0;
    repeat (20) begin tick(); nv += int'(audio_valid); end
    chk("rate0_valid", nv, 0);
    chk("rate0_level", 32'(fifo_level), 1);

    repeat (12) begin
      active_ch = 3'($urandom_range(0, 7));
      mode_16bit = 1'($urandom_range(0, 1));
      volume = 8'($urandom);
      rate = 8'($urandom_range(128, 255));
      repeat ($urandom_range(0, 20)) push(8'($urandom));
      do_frame("rnd");
    end

    flush();
    active_ch = 3'd1; mode_16bit = 1; volume = 8'($urandom); rate = 8'd32;
    repeat (20) push(8'($urandom));
    nv = 0;
    repeat (16) begin
      next_sample = 1; tick(); nv += int'(audio_valid); next_sample = 0;
      repeat (11) begin tick(); nv += int'(audio_valid); end
    end
    repeat (4) model(lat);
    chk("t4_frames", nv, 4);
    chk("t4_level", 32'(fifo_level), 4);
    check_out("t4");

    flush();
    for (int i = 1; i <= DEPTH + 1; i++) begin
      push(8'($urandom));
      if (i == AE - 1) chk("ae_below", 32'(fifo_almost_empty), 1);
      if (i == AE) chk("ae_at", 32'(fifo_almost_empty), 0);
      if (i == DEPTH - 1) chk("full_before", 32'(fifo_full), 0);
      if (i == DEPTH) chk("full_at", 32'(fifo_full), 1);
    end
    chk("full_level", 32'(fifo_level), DEPTH);
    rate = 8'd128; active_ch = 3'd0; mode_16bit = 0; volume = 8'($urandom);
    do_frame("t5");
    fifo_reset = 1; fifo_write = 1; fifo_wrdata = 8'h55;
    tick();
    fifo_reset = 0; fifo_write = 0;
    q.delete(); exp_ur = 0;
    chk("t5_flush_level", 32'(fifo_level), 0);
    chk("t5_flush_empty", 32'(fifo_empty), 1);

    volume = 8'hFF;
    push(8'h40);
    do_frame("pre_abort");
    active_ch = 3'd1; mode_16bit = 1;
    repeat (4) push(8'($urandom));
    next_sample = 1; tick(); next_sample = 0;
    tick(); tick();
    fifo_reset = 1; tick(); fifo_reset = 0;
    q.delete();
    nv = 0;
    repeat (20) begin tick(); nv += int'(audio_valid); end
    chk("abort_valid", nv, 0);
    chk("abort_level", 32'(fifo_level), 0);
    check_out("abort_hold");

    repeat (4) push(8'($urandom));
    next_sample = 1; tick(); next_sample = 0;
    tick(); tick();
    #1 rst = 1;
    #1;
    chk("arst_out", audio_out, 0);
    chk("arst_valid", 32'(audio_valid), 0);
    chk("arst_level", 32'(fifo_level), 0);
    chk("arst_empty", 32'(fifo_empty), 1);
    tick();
    rst = 0;
    q.delete(); exp_ur = 0;
    for (int l = 0; l < NCH; l++) exp_out[l] = '0;
    tick();
    active_ch = 3'd0; mode_16bit = 0;
    push(8'h40);
    do_frame("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
